clause_sweep_ctrl: RTL
======================

CLAUSE_SWEEP_CTRL -- requirements
Module: clause_sweep_ctrl

Interface
REQ-001 Parameter NUM_CLAUSES, default 64: total clauses held in clause memory.
REQ-002 Parameter NUM_CLAUSES_PER_CYCLE, default 16: clauses per memory row.
REQ-003 Parameter EARLY_EXIT, default 1: 1 = end the sweep on the first unsatisfied row; 0 = always scan all rows.
REQ-004 Derived NUM_ROWS = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE; PTR_BITS = max(1, $clog2(NUM_ROWS)).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a sweep when idle.
REQ-008 abort  in  1  cancels an active sweep.
REQ-009 row_addr  out  PTR_BITS  clause-memory row address; memory returns that row one cycle later.
REQ-010 slice_valid  out  1  current memory slice is presented to the evaluator.
REQ-011 slice_ready  in  1  evaluator accepts the slice.
REQ-012 row_unsat  in  1  evaluator verdict for the presented slice; sampled only on accept (slice_valid && slice_ready).
REQ-013 busy  out  1  sweep in progress.
REQ-014 done  out  1  one-cycle pulse when a sweep completes (not on abort).
REQ-015 sweep_sat  out  1  registered: 1 = no row reported unsat in the last completed sweep.
REQ-016 first_unsat_row  out  PTR_BITS  registered: lowest row index reported unsat in the last completed sweep; 0 if none.

Function
REQ-017 The FSM SHALL have states IDLE, READ, PRESENT and DONE.
REQ-018 IDLE: on start, the block SHALL set row_addr=0, clear the internal unsat flag and go to READ.
REQ-019 READ SHALL last exactly one cycle, covering memory read latency, then go to PRESENT.
REQ-020 PRESENT SHALL assert slice_valid and hold row_addr stable until accept.
REQ-021 On accept with row_unsat=1 and no earlier unsat in this sweep, the block SHALL record row_addr as the first unsat row.
REQ-022 After accept, the FSM SHALL go to DONE if row_addr==NUM_ROWS-1, or if EARLY_EXIT=1 and row_unsat=1; otherwise it SHALL increment row_addr and go to READ.
REQ-023 Per-row throughput SHALL be 2 cycles with slice_ready held high; a full sweep is 2*NUM_ROWS cycles from the start cycle to DONE entry.
REQ-024 DONE SHALL last one cycle, pulse done, update sweep_sat and first_unsat_row, then return to IDLE.
REQ-025 busy SHALL be 1 in READ, PRESENT and DONE, and 0 in IDLE.
REQ-026 start SHALL be ignored while busy.
REQ-027 abort SHALL take priority over all other events in READ or PRESENT: next state IDLE, no done pulse, result registers unchanged, no accept counted in that cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 row_addr SHALL never exceed NUM_ROWS-1 and SHALL NOT wrap within a sweep.
REQ-030 With NUM_ROWS=1, the sweep SHALL be READ, PRESENT, DONE.
REQ-031 slice_ready while slice_valid=0 SHALL be ignored.

Reset
REQ-032 rst SHALL override every input, including start and abort in the same cycle.
REQ-033 Reset values: FSM=IDLE, row_addr=0, slice_valid=0, busy=0, done=0, sweep_sat=1, first_unsat_row=0, unsat flag=0.
REQ-034 Reset during an active sweep SHALL discard it with no done pulse.

Structure
REQ-035 NUM_CLAUSES, NUM_CLAUSES_PER_CYCLE, VAR_ID_BITS, NUM_VARS_PER_CLAUSE and the FSM state enum SHALL live in shared package sat_pkg.
REQ-036 A single sub-module row_counter (load-zero, increment, terminal-count flag) SHALL be used; everything else is flat.

Verification
REQ-037 Defaults, ready held 1, row_unsat always 0, start -> done exactly 8 cycles after start, sweep_sat=1, first_unsat_row=0, row_addr sequence 0,1,2,3.
REQ-038 EARLY_EXIT=1, row_unsat=1 on row 2 only -> done after row 2 accept, sweep_sat=0, first_unsat_row=2, row 3 never presented.
REQ-039 EARLY_EXIT=0, unsat on rows 1 and 3 -> all 4 rows presented, first_unsat_row=1, sweep_sat=0.
REQ-040 slice_ready low for 5 cycles on row 1 -> slice_valid and row_addr=1 held stable, done 5 cycles later than REQ-037.
REQ-041 abort in PRESENT of row 2 after a previous unsat sweep -> IDLE next cycle, no done, sweep_sat and first_unsat_row keep prior values; a new start then works normally.
REQ-042 rst asserted in the same cycle as start, and again mid-sweep -> all outputs at reset values next cycle, no done pulse.

Source files
------------

// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the clause-evaluation datapath: clause memory
// geometry, variable/clause encoding widths, the sweep controller state
// type and a pointer-width helper.
// ---------------------------------------------------------------------------
package sat_pkg;

    // Clause memory geometry
    localparam int NUM_CLAUSES           = 64;
    localparam int NUM_CLAUSES_PER_CYCLE = 16;

    // Clause encoding
    localparam int VAR_ID_BITS           = 8;
    localparam int NUM_VARS_PER_CLAUSE   = 3;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } sweep_state_t;

    // Row pointer width; a single-row memory still needs a 1-bit address.
    function automatic int ptr_bits_for(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/row_counter.sv
// ---------------------------------------------------------------------------
// row_counter
// Clause-memory row pointer with synchronous clear and saturating increment.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (count -> 0)
//   clr      in   load zero
//   inc      in   advance to the next row (ignored at the last row)
//   count    out  current row index
//   at_last  out  count == NUM_ROWS-1
// ---------------------------------------------------------------------------
module row_counter
    import sat_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int PTR_BITS = ptr_bits_for(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [PTR_BITS-1:0] count,
    output logic                at_last
);

    localparam logic [PTR_BITS-1:0] LAST_ROW = PTR_BITS'(NUM_ROWS - 1);

    assign at_last = (count == LAST_ROW);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !at_last) begin
            // Saturate rather than wrap: the pointer never leaves the memory.
            count <= count + PTR_BITS'(1);
        end
    end

endmodule

// File: rtl/clause_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// clause_sweep_ctrl
// Walks the clause memory one row at a time, presenting each row to the
// clause evaluator and collecting the verdicts into a sweep result.
// Each row costs one READ cycle (memory latency) plus at least one PRESENT
// cycle (handshake), so an unstalled sweep takes 2*NUM_ROWS cycles.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset, overrides all inputs
//   start            in   begin a sweep (ignored while busy)
//   abort            in   cancel an active sweep (READ/PRESENT only)
//   row_addr         out  clause-memory row address
//   slice_valid      out  current row is presented to the evaluator
//   slice_ready      in   evaluator accepts the row
//   row_unsat        in   evaluator verdict, sampled on accept
//   busy             out  sweep in progress
//   done             out  one-cycle pulse on sweep completion
//   sweep_sat        out  last completed sweep saw no unsat row
//   first_unsat_row  out  lowest unsat row of last completed sweep (0 if none)
// ---------------------------------------------------------------------------
module clause_sweep_ctrl #(
    parameter int   NUM_CLAUSES           = sat_pkg::NUM_CLAUSES,
    parameter int   NUM_CLAUSES_PER_CYCLE = sat_pkg::NUM_CLAUSES_PER_CYCLE,
    parameter bit   EARLY_EXIT            = 1'b1,
    localparam int  NUM_ROWS              = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int  PTR_BITS              = sat_pkg::ptr_bits_for(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [PTR_BITS-1:0] row_addr,
    output logic                slice_valid,
    input  logic                slice_ready,
    input  logic                row_unsat,
    output logic                busy,
    output logic                done,
    output logic                sweep_sat,
    output logic [PTR_BITS-1:0] first_unsat_row
);

    import sat_pkg::*;

    sweep_state_t        state;
    logic                unsat_seen;   // an unsat row was accepted this sweep
    logic [PTR_BITS-1:0] first_idx;    // row of the first unsat accept

    logic last_row;
    logic accept;
    logic finish;
    logic cnt_clr;
    logic cnt_inc;

    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment would infer a latch.
    always_comb begin
        // slice_valid is only high in PRESENT, so ready outside it is ignored.
        accept  = slice_valid && slice_ready && !abort;
        finish  = accept && (last_row || (EARLY_EXIT && row_unsat));
        cnt_clr = (state == ST_IDLE) && start;
        cnt_inc = accept && !finish;
    end

    row_counter #(
        .NUM_ROWS (NUM_ROWS),
        .PTR_BITS (PTR_BITS)
    ) u_row_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .count   (row_addr),
        .at_last (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            slice_valid     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sweep_sat       <= 1'b1;
            first_unsat_row <= '0;
            unsat_seen      <= 1'b0;
            first_idx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_READ;
                        busy       <= 1'b1;
                        unsat_seen <= 1'b0;
                        first_idx  <= '0;
                    end
                end

                ST_READ: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Memory data for row_addr is available from here on.
                        state       <= ST_PRESENT;
                        slice_valid <= 1'b1;
                    end
                end

                ST_PRESENT: begin
                    if (abort) begin
                        state       <= ST_IDLE;
                        slice_valid <= 1'b0;
                        busy        <= 1'b0;
                    end else if (accept) begin
                        slice_valid <= 1'b0;
                        if (row_unsat && !unsat_seen) begin
                            unsat_seen <= 1'b1;
                            first_idx  <= row_addr;
                        end
                        if (finish) begin
                            // Results are published together with the done
                            // pulse, so they fold in this final verdict.
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            sweep_sat <= !(unsat_seen || row_unsat);
                            if (unsat_seen) begin
                                first_unsat_row <= first_idx;
                            end else if (row_unsat) begin
                                first_unsat_row <= row_addr;
                            end else begin
                                first_unsat_row <= '0;
                            end
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state       <= ST_IDLE;
                    slice_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
